// File: rtl/snake_move_ctrl_if.sv
// Signal bundle between the game-state FSM / button debouncers and the
// snake movement controller. The controller sits on the slave side.
interface snake_move_ctrl_if #(
    parameter int STEP_W = 16
);
    logic [2:0]        state;
    logic [27:0]       mov_speed;
    logic              up_p;
    logic              right_p;
    logic              down_p;
    logic              left_p;
    logic              move_tick;
    logic [1:0]        dir;
    logic [1:0]        q_count;
    logic [STEP_W-1:0] step_count;

    modport master (
        output state, mov_speed, up_p, right_p, down_p, left_p,
        input  move_tick, dir, q_count, step_count
    );

    modport slave (
        input  state, mov_speed, up_p, right_p, down_p, left_p,
        output move_tick, dir, q_count, step_count
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake movement timebase and heading control.
// Produces a one-cycle move_tick every latched period while playing and
// commits at most one buffered turn per tick from a 2-entry queue.
//
// state (input) | meaning
// 0 START       | idle screen: counter cleared, queue flushed, heading RIGHT
// 1 CHOOSE      | level select: as START
// 2 IDLE        | ready: latch period, clear step count, as START
// 3 PLAY        | count down to ticks, accept turns, commit on tick
// 4 PAUSE       | everything frozen, buttons ignored
// 5 WIN         | as START, step count kept for display
module snake_move_ctrl #(
    parameter int MIN_PERIOD = 2,
    parameter int STEP_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    snake_move_ctrl_if.slave  bus
);
    localparam logic [2:0]  ST_IDLE  = 3'd2;
    localparam logic [2:0]  ST_PLAY  = 3'd3;
    localparam logic [2:0]  ST_PAUSE = 3'd4;
    localparam logic [1:0]  DIR_RIGHT = 2'd1;
    localparam logic [27:0] MIN_P = 28'(MIN_PERIOD);

    logic [27:0]       period_q, period_d;
    logic [27:0]       cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [1:0]        dir_q, dir_d;
    logic [1:0]        q0_q, q0_d;
    logic [1:0]        q1_q, q1_d;
    logic [1:0]        qc_q, qc_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic              tick_fire;
    logic              pop;
    logic [1:0]        qc_after;
    logic [1:0]        ref_dir;
    logic              req_vld;
    logic [1:0]        req_dir;

    // Button priority: UP > RIGHT > DOWN > LEFT, one request per cycle.
    always_comb begin
        req_vld = bus.up_p | bus.right_p | bus.down_p | bus.left_p;
        req_dir = 2'd3;
        if (bus.up_p)         req_dir = 2'd0;
        else if (bus.right_p) req_dir = 2'd1;
        else if (bus.down_p)  req_dir = 2'd2;
    end

    // Next-state: period latch, tick counter, turn queue and heading.
    always_comb begin
        period_d  = period_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        dir_d     = dir_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        qc_d      = qc_q;
        step_d    = step_q;
        tick_fire = 1'b0;
        pop       = 1'b0;
        qc_after  = qc_q;
        ref_dir   = dir_q;

        case (bus.state)
            ST_IDLE: begin
                period_d = (bus.mov_speed > MIN_P) ? bus.mov_speed : MIN_P;
                cnt_d    = '0;
                qc_d     = '0;
                dir_d    = DIR_RIGHT;
                step_d   = '0;
            end
            ST_PLAY: begin
                tick_fire = (cnt_q == period_q - 28'd1);
                cnt_d     = tick_fire ? '0 : cnt_q + 28'd1;
                tick_d    = tick_fire;
                pop       = tick_fire && (qc_q != 2'd0);
                if (tick_fire && (step_q != {STEP_W{1'b1}}))
                    step_d = step_q + 1'b1;
                if (pop) begin
                    dir_d = q0_q;
                    q0_d  = q1_q;
                end
                qc_after = qc_q - {1'b0, pop};
                // New turns are judged against the last heading they would follow.
                if (qc_after == 2'd2)
                    ref_dir = q1_q;
                else if (qc_after == 2'd1)
                    ref_dir = pop ? q1_q : q0_q;
                else
                    ref_dir = dir_d;
                qc_d = qc_after;
                if (req_vld && (req_dir != ref_dir) &&
                    (req_dir != (ref_dir ^ 2'd2)) && (qc_after != 2'd2)) begin
                    if (qc_after == 2'd0) q0_d = req_dir;
                    else                  q1_d = req_dir;
                    qc_d = qc_after + 2'd1;
                end
            end
            ST_PAUSE: begin
                tick_d = 1'b0;
            end
            default: begin
                cnt_d = '0;
                qc_d  = '0;
                dir_d = DIR_RIGHT;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= MIN_P;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            dir_q    <= DIR_RIGHT;
            q0_q     <= '0;
            q1_q     <= '0;
            qc_q     <= '0;
            step_q   <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            dir_q    <= dir_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            qc_q     <= qc_d;
            step_q   <= step_d;
        end
    end

    assign bus.move_tick  = tick_q;
    assign bus.dir        = dir_q;
    assign bus.q_count    = qc_q;
    assign bus.step_count = step_q;
endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed and randomized checks of snake_move_ctrl against a queue-based
// behavioural model.
module tb_snake_move_ctrl;
    localparam int STEP_W = 16;
    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_UP   = 4'b1000;
    localparam logic [3:0] B_RT   = 4'b0100;
    localparam logic [3:0] B_DN   = 4'b0010;
    localparam logic [3:0] B_LT   = 4'b0001;

    logic clk = 1'b0;
    logic rst;

    snake_move_ctrl_if #(.STEP_W(STEP_W)) bus ();

    snake_move_ctrl #(.MIN_PERIOD(2), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model
    int m_period;
    int m_elapsed;
    int m_tick;
    int m_dir;
    int m_step;
    int m_q[$];

    task automatic model_reset();
        m_period  = 2;
        m_elapsed = 0;
        m_tick    = 0;
        m_dir     = 1;
        m_step    = 0;
        m_q.delete();
    endtask

    task automatic model_step(input int st, input int spd, input logic [3:0] b);
        int req;
        int rd;
        case (st)
            2: begin
                m_period  = (spd < 2) ? 2 : spd;
                m_elapsed = 0;
                m_tick    = 0;
                m_q.delete();
                m_dir     = 1;
                m_step    = 0;
            end
            3: begin
                m_elapsed++;
                m_tick = ((m_elapsed % m_period) == 0) ? 1 : 0;
                if (m_tick == 1) begin
                    if (m_q.size() > 0) m_dir = m_q.pop_front();
                    if (m_step < (1 << STEP_W) - 1) m_step++;
                end
                if (b != 4'b0000) begin
                    req = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
                    rd  = (m_q.size() > 0) ? m_q[$] : m_dir;
                    if (req != rd && req != ((rd + 2) % 4) && m_q.size() < 2)
                        m_q.push_back(req);
                end
            end
            4: m_tick = 0;
            default: begin
                m_elapsed = 0;
                m_tick    = 0;
                m_q.delete();
                m_dir     = 1;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("move_tick",  32'(bus.move_tick),  32'(m_tick));
        check("dir",        32'(bus.dir),        32'(m_dir));
        check("q_count",    32'(bus.q_count),    32'(m_q.size()));
        check("step_count", 32'(bus.step_count), 32'(m_step));
    endtask

    task automatic step(input int st, input int spd, input logic [3:0] b);
        bus.state     = 3'(st);
        bus.mov_speed = 28'(spd);
        {bus.up_p, bus.right_p, bus.down_p, bus.left_p} = b;
        @(posedge clk);
        model_step(st, spd, b);
        #1;
        check_all();
    endtask

    initial begin
        int tick_mask;
        int n_ticks;
        int cur_st;
        int pick;
        logic [3:0] btn;

        rst           = 1'b1;
        bus.state     = 3'd0;
        bus.mov_speed = 28'd0;
        {bus.up_p, bus.right_p, bus.down_p, bus.left_p} = B_NONE;
        #2;
        model_reset();
        check_all();
        #21;
        rst = 1'b0;

        // basic timebase, period 4
        step(2, 4, B_NONE);
        step(2, 4, B_NONE);
        tick_mask = 0;
        for (int i = 1; i <= 19; i++) begin
            step(3, 4, B_NONE);
            if (bus.move_tick === 1'b1) tick_mask |= (1 << i);
        end
        check("tick_pattern", 32'(tick_mask), 32'((1 << 4) | (1 << 8) | (1 << 12) | (1 << 16)));
        check("play_steps", 32'(bus.step_count), 32'd4);
        check("play_dir", 32'(bus.dir), 32'd1);
        step(3, 4, B_NONE);

        // period clamp
        step(2, 1, B_NONE);
        n_ticks = 0;
        for (int i = 1; i <= 8; i++) begin
            step(3, 1, B_NONE);
            if (bus.move_tick === 1'b1) n_ticks++;
        end
        check("clamp_ticks", 32'(n_ticks), 32'd4);

        // pause freezes the counter; mov_speed changes are ignored
        step(2, 4, B_NONE);
        step(3, 4, B_NONE);
        step(3, 4, B_NONE);
        repeat (7) step(4, 9, B_UP);
        step(3, 9, B_NONE);
        check("resume_1", 32'(bus.move_tick), 32'd0);
        step(3, 9, B_NONE);
        check("resume_2", 32'(bus.move_tick), 32'd1);

        // reversal rejection and two queued turns
        step(2, 8, B_NONE);
        step(3, 8, B_LT);
        check("reverse_drop", 32'(bus.q_count), 32'd0);
        step(3, 8, B_UP);
        step(3, 8, B_LT);
        check("two_queued", 32'(bus.q_count), 32'd2);
        repeat (5) step(3, 8, B_NONE);
        check("first_commit", 32'(bus.dir), 32'd0);
        repeat (8) step(3, 8, B_NONE);
        check("second_commit", 32'(bus.dir), 32'd3);

        // push coinciding with pop on a full queue
        step(2, 4, B_NONE);
        step(3, 4, B_UP);
        step(3, 4, B_LT);
        step(3, 4, B_NONE);
        step(3, 4, B_DN);
        check("full_pop_dir", 32'(bus.dir), 32'd0);
        check("full_pop_q", 32'(bus.q_count), 32'd2);
        repeat (8) step(3, 4, B_NONE);

        // simultaneous buttons: only the highest priority one is taken
        step(2, 4, B_NONE);
        step(3, 4, B_UP | B_LT);
        check("multi_press", 32'(bus.q_count), 32'd1);
        repeat (4) step(3, 4, B_NONE);

        // WIN mid-play flushes the queue
        step(2, 4, B_NONE);
        step(3, 4, B_UP);
        step(3, 4, B_LT);
        step(3, 4, B_NONE);
        step(5, 4, B_NONE);
        check("win_q", 32'(bus.q_count), 32'd0);
        check("win_dir", 32'(bus.dir), 32'd1);
        check("win_tick", 32'(bus.move_tick), 32'd0);
        step(5, 4, B_RT);

        // reset mid-play
        step(2, 4, B_NONE);
        step(3, 4, B_UP);
        step(3, 4, B_NONE);
        step(3, 4, B_NONE);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(3, 4, B_NONE);
        check("post_reset_tick", 32'(bus.move_tick), 32'd0);
        repeat (4) step(3, 4, B_NONE);

        // randomized traffic
        cur_st = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                pick = $urandom_range(0, 7);
                case (pick)
                    0: cur_st = 0;
                    1: cur_st = 1;
                    2: cur_st = 2;
                    6: cur_st = 4;
                    7: cur_st = 5;
                    default: cur_st = 3;
                endcase
            end
            btn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
            step(cur_st, $urandom_range(0, 7), btn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
